// File: rtl/fma_norm_stage.sv
// fma_norm_stage: post-multiply normalization for the FMA datapath.
//
// Takes the absolute-value product with its leading-zero-anticipator shift count,
// left-normalizes it, applies the one-bit LZA correction and adjusts the exponents.
// It supports one wide lane (double / single-in-wide-lane) or two packed 37-bit
// single lanes. The work is split into two stages with valid/ready backpressure:
//   N1 : coarse barrel shift by the LZA count, exponent minus shift, lane-zero detect
//   N2 : one-bit LZA correction per lane, zero-lane exponent forcing
//
// Ports
//   clk, rstn           clock (posedge) and asynchronous active-low reset
//   flush               clears both stage valids on the next edge, drops the offered beat
//   in_vld / in_rdy     input handshake (in_rdy is combinational)
//   cont_in             000 double, 010 single wide, 001 packed singles, others reserved
//   p_reg_in            magnitude; packed hi lane [74:38], lo lane [36:0], bit 37 ignored
//   sh_num_in           wide [6:0]; packed hi [9:5], lo [4:0]
//   esh_in              per lane: shift already exponent-limited, skip correction
//   e_in / eh_in        wide-or-lo / hi exponent, two's complement
//   sgn_in, trap_in     forwarded unchanged
//   out_vld / out_rdy   output handshake
//   m_out, e_out, eh_out normalized magnitude and adjusted exponents
//   z_out               lane magnitude zero [1] hi/wide, [0] lo
//   sgn_out, trap_out, cont_out  forwarded fields
//   rsv_err             beat carried a reserved cont encoding
module fma_norm_stage #(
  parameter int unsigned MW = 75,
  parameter int unsigned EW = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [2:0]    cont_in,
  input  logic [MW-1:0] p_reg_in,
  input  logic [9:0]    sh_num_in,
  input  logic [1:0]    esh_in,
  input  logic [EW-1:0] e_in,
  input  logic [EW-1:0] eh_in,
  input  logic [1:0]    sgn_in,
  input  logic [13:0]   trap_in,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [MW-1:0] m_out,
  output logic [EW-1:0] e_out,
  output logic [EW-1:0] eh_out,
  output logic [1:0]    z_out,
  output logic [1:0]    sgn_out,
  output logic [13:0]   trap_out,
  output logic [2:0]    cont_out,
  output logic          rsv_err
);

  // Packed lane geometry: two LW-bit lanes separated by one unused bit.
  localparam int unsigned LW = (MW - 1) / 2;
  localparam int unsigned HL = MW - LW;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic r1_vld;
  logic r2_vld;
  logic w_s2_adv;
  logic w_s1_load;
  logic w_s2_load;

  assign w_s2_adv  = !r2_vld || out_rdy;
  assign in_rdy    = !r1_vld || w_s2_adv;
  assign w_s1_load = in_vld && in_rdy && !flush;
  assign w_s2_load = r1_vld && w_s2_adv && !flush;

  // ---------------------------------------------------------------------------
  // N1: mode decode, coarse shift, exponent minus shift, zero detect
  // ---------------------------------------------------------------------------
  logic          w_packed;
  logic          w_rsv;
  logic [6:0]    w_wsh;
  logic [LW-1:0] w_hi_in;
  logic [LW-1:0] w_lo_in;
  logic [LW-1:0] w_hi_sh;
  logic [LW-1:0] w_lo_sh;
  logic [MW-1:0] w_m1;
  logic [EW-1:0] w_e1;
  logic [EW-1:0] w_eh1;
  logic [1:0]    w_z1;

  always_comb begin
    w_packed = 1'b0;
    w_rsv    = 1'b0;
    case (cont_in)
      3'b000, 3'b010: w_rsv    = 1'b0;
      3'b001:         w_packed = 1'b1;
      default:        w_rsv    = 1'b1;  // reserved encodings travel as wide
    endcase
  end

  assign w_hi_in = p_reg_in[MW-1:HL];
  assign w_lo_in = p_reg_in[LW-1:0];
  assign w_hi_sh = w_hi_in << sh_num_in[9:5];
  assign w_lo_sh = w_lo_in << sh_num_in[4:0];

  // Wide shift clamps so a bogus count can never exceed the magnitude width.
  assign w_wsh = (sh_num_in[6:0] > 7'(MW - 1)) ? 7'(MW - 1) : sh_num_in[6:0];

  always_comb begin
    w_m1  = p_reg_in << w_wsh;
    w_e1  = e_in - EW'(w_wsh);
    w_eh1 = '0;
    w_z1  = {(p_reg_in == '0), 1'b0};
    if (w_packed) begin
      w_m1  = {w_hi_sh, 1'b0, w_lo_sh};
      w_e1  = e_in - EW'(sh_num_in[4:0]);
      w_eh1 = eh_in - EW'(sh_num_in[9:5]);
      w_z1  = {(w_hi_in == '0), (w_lo_in == '0)};
    end
  end

  // Stage 1 registers
  logic [MW-1:0] r1_m;
  logic [EW-1:0] r1_e;
  logic [EW-1:0] r1_eh;
  logic [1:0]    r1_z;
  logic [1:0]    r1_esh;
  logic          r1_packed;
  logic          r1_rsv;
  logic [1:0]    r1_sgn;
  logic [13:0]   r1_trap;
  logic [2:0]    r1_cont;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r1_vld    <= 1'b0;
      r1_m      <= '0;
      r1_e      <= '0;
      r1_eh     <= '0;
      r1_z      <= '0;
      r1_esh    <= '0;
      r1_packed <= 1'b0;
      r1_rsv    <= 1'b0;
      r1_sgn    <= '0;
      r1_trap   <= '0;
      r1_cont   <= '0;
    end else begin
      if (flush) begin
        r1_vld <= 1'b0;
      end else if (in_rdy) begin
        r1_vld <= in_vld;
      end
      if (w_s1_load) begin
        r1_m      <= w_m1;
        r1_e      <= w_e1;
        r1_eh     <= w_eh1;
        r1_z      <= w_z1;
        r1_esh    <= esh_in;
        r1_packed <= w_packed;
        r1_rsv    <= w_rsv;
        r1_sgn    <= sgn_in;
        r1_trap   <= trap_in;
        r1_cont   <= cont_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // N2: one-bit LZA correction and zero-lane exponent forcing
  // ---------------------------------------------------------------------------
  // The hi lane and the wide magnitude share the same MSB position.
  logic          w_c_hi;
  logic          w_c_lo;
  logic [LW-1:0] w_hi1;
  logic [LW-1:0] w_lo1;
  logic [MW-1:0] w_m2;
  logic [EW-1:0] w_e2;
  logic [EW-1:0] w_eh2;

  assign w_c_hi = !r1_m[MW-1] && !r1_z[1] && !r1_esh[1];
  assign w_c_lo = !r1_m[LW-1] && !r1_z[0] && !r1_esh[0];
  assign w_hi1  = r1_m[MW-1:HL];
  assign w_lo1  = r1_m[LW-1:0];

  always_comb begin
    w_m2  = w_c_hi ? (r1_m << 1) : r1_m;
    w_e2  = r1_z[1] ? '0 : (r1_e - EW'(w_c_hi));
    w_eh2 = '0;
    if (r1_packed) begin
      w_m2  = {(w_c_hi ? (w_hi1 << 1) : w_hi1), 1'b0, (w_c_lo ? (w_lo1 << 1) : w_lo1)};
      w_e2  = r1_z[0] ? '0 : (r1_e - EW'(w_c_lo));
      w_eh2 = r1_z[1] ? '0 : (r1_eh - EW'(w_c_hi));
    end
  end

  // Stage 2 registers drive the outputs directly.
  logic [MW-1:0] r2_m;
  logic [EW-1:0] r2_e;
  logic [EW-1:0] r2_eh;
  logic [1:0]    r2_z;
  logic [1:0]    r2_sgn;
  logic [13:0]   r2_trap;
  logic [2:0]    r2_cont;
  logic          r2_rsv;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r2_vld  <= 1'b0;
      r2_m    <= '0;
      r2_e    <= '0;
      r2_eh   <= '0;
      r2_z    <= '0;
      r2_sgn  <= '0;
      r2_trap <= '0;
      r2_cont <= '0;
      r2_rsv  <= 1'b0;
    end else begin
      if (flush) begin
        r2_vld <= 1'b0;
      end else if (w_s2_adv) begin
        r2_vld <= r1_vld;
      end
      if (w_s2_load) begin
        r2_m    <= w_m2;
        r2_e    <= w_e2;
        r2_eh   <= w_eh2;
        r2_z    <= r1_z;
        r2_sgn  <= r1_sgn;
        r2_trap <= r1_trap;
        r2_cont <= r1_cont;
        r2_rsv  <= r1_rsv;
      end
    end
  end

  assign out_vld  = r2_vld;
  assign m_out    = r2_m;
  assign e_out    = r2_e;
  assign eh_out   = r2_eh;
  assign z_out    = r2_z;
  assign sgn_out  = r2_sgn;
  assign trap_out = r2_trap;
  assign cont_out = r2_cont;
  assign rsv_err  = r2_rsv;

endmodule

// File: tb/tb_fma_norm_stage.sv
// Directed bench for fma_norm_stage: wide/packed normalization, LZA correction,
// zero lanes, reserved cont, backpressure, flush and asynchronous reset.
module tb_fma_norm_stage;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        in_vld;
  logic        in_rdy;
  logic [2:0]  cont_in;
  logic [74:0] p_reg_in;
  logic [9:0]  sh_num_in;
  logic [1:0]  esh_in;
  logic [11:0] e_in;
  logic [11:0] eh_in;
  logic [1:0]  sgn_in;
  logic [13:0] trap_in;
  logic        out_vld;
  logic        out_rdy;
  logic [74:0] m_out;
  logic [11:0] e_out;
  logic [11:0] eh_out;
  logic [1:0]  z_out;
  logic [1:0]  sgn_out;
  logic [13:0] trap_out;
  logic [2:0]  cont_out;
  logic        rsv_err;

  int n_checks;
  int n_pass;
  int n_fail;

  fma_norm_stage #(.MW(75), .EW(12)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .cont_in   (cont_in),
    .p_reg_in  (p_reg_in),
    .sh_num_in (sh_num_in),
    .esh_in    (esh_in),
    .e_in      (e_in),
    .eh_in     (eh_in),
    .sgn_in    (sgn_in),
    .trap_in   (trap_in),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .m_out     (m_out),
    .e_out     (e_out),
    .eh_out    (eh_out),
    .z_out     (z_out),
    .sgn_out   (sgn_out),
    .trap_out  (trap_out),
    .cont_out  (cont_out),
    .rsv_err   (rsv_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [74:0] obs, input logic [74:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [2:0] c, input logic [74:0] p, input logic [9:0] sh,
                       input logic [1:0] es, input logic [11:0] e, input logic [11:0] eh,
                       input logic [1:0] s, input logic [13:0] t);
    cont_in   = c;
    p_reg_in  = p;
    sh_num_in = sh;
    esh_in    = es;
    e_in      = e;
    eh_in     = eh;
    sgn_in    = s;
    trap_in   = t;
    in_vld    = 1'b1;
  endtask

  // Offer one beat with out_rdy high and confirm it appears exactly two edges later.
  task automatic run_beat(input string tag);
    tick();
    in_vld = 1'b0;
    chk({tag, "_lat1"}, 75'(out_vld), 75'(1'b0));
    tick();
    chk({tag, "_lat2"}, 75'(out_vld), 75'(1'b1));
  endtask

  logic [11:0] bp_exp_e [4];
  int          bp_idx;
  int          bp_got;
  logic        bp_fin;
  logic        bp_fout;

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    n_fail    = 0;
    rstn      = 1'b0;
    flush     = 1'b0;
    in_vld    = 1'b0;
    out_rdy   = 1'b1;
    cont_in   = '0;
    p_reg_in  = '0;
    sh_num_in = '0;
    esh_in    = '0;
    e_in      = '0;
    eh_in     = '0;
    sgn_in    = '0;
    trap_in   = '0;

    // Reset state
    #12;
    chk("rst_out_vld", 75'(out_vld), 75'(1'b0));
    chk("rst_m", m_out, 75'h0);
    chk("rst_e", 75'(e_out), 75'h0);
    chk("rst_in_rdy", 75'(in_rdy), 75'(1'b1));
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("post_rst_in_rdy", 75'(in_rdy), 75'(1'b1));

    // Wide: 1<<16 shifted 58 -> MSB, e = 100 - 58
    apply(3'b000, 75'h0_0000_0000_0001_0000, 10'd58, 2'b00, 12'd100, 12'd0, 2'b10, 14'h1234);
    run_beat("wide");
    chk("wide_m", m_out, 75'h1 << 74);
    chk("wide_e", 75'(e_out), 75'd42);
    chk("wide_eh", 75'(eh_out), 75'd0);
    chk("wide_z", 75'(z_out), 75'(2'b00));
    chk("wide_sgn", 75'(sgn_out), 75'(2'b10));
    chk("wide_trap", 75'(trap_out), 75'h1234);
    chk("wide_rsv", 75'(rsv_err), 75'(1'b0));
    tick();
    chk("wide_drained", 75'(out_vld), 75'(1'b0));

    // LZA one short: correction shifts once more, e = 100 - 57 - 1
    apply(3'b000, 75'h1 << 16, 10'd57, 2'b00, 12'd100, 12'd0, 2'b00, 14'h0);
    run_beat("corr");
    chk("corr_m", m_out, 75'h1 << 74);
    chk("corr_e", 75'(e_out), 75'd42);

    // Same with the wide esh bit set: no correction
    apply(3'b010, 75'h1 << 16, 10'd57, 2'b10, 12'd100, 12'd0, 2'b00, 14'h0);
    run_beat("esh");
    chk("esh_m", m_out, 75'h1 << 73);
    chk("esh_e", 75'(e_out), 75'd43);
    chk("esh_cont", 75'(cont_out), 75'(3'b010));

    // Wide clamp: shift 127 limited to 74
    apply(3'b000, 75'h1, 10'd127, 2'b00, 12'd100, 12'd0, 2'b00, 14'h0);
    run_beat("clamp");
    chk("clamp_m", m_out, 75'h1 << 74);
    chk("clamp_e", 75'(e_out), 75'd26);

    // Exponent wrap: 5 - 10 = -5
    apply(3'b000, 75'h1 << 64, 10'd10, 2'b00, 12'd5, 12'd0, 2'b00, 14'h0);
    run_beat("wrap");
    chk("wrap_m", m_out, 75'h1 << 74);
    chk("wrap_e", 75'(e_out), 75'hFFB);

    // Wide zero magnitude
    apply(3'b000, 75'h0, 10'd5, 2'b00, 12'd100, 12'd0, 2'b00, 14'h0);
    run_beat("wzero");
    chk("wzero_m", m_out, 75'h0);
    chk("wzero_e", 75'(e_out), 75'd0);
    chk("wzero_z", 75'(z_out), 75'(2'b10));

    // Packed: hi lane 1 shifted 31 (esh set, no correction), lo lane zero
    apply(3'b001, 75'h1 << 38, {5'd31, 5'd0}, 2'b11, 12'd50, 12'd200, 2'b01, 14'h0);
    run_beat("pk");
    chk("pk_m", m_out, 75'h1 << 69);
    chk("pk_eh", 75'(eh_out), 75'd169);
    chk("pk_e", 75'(e_out), 75'd0);
    chk("pk_z", 75'(z_out), 75'(2'b01));
    chk("pk_sgn", 75'(sgn_out), 75'(2'b01));

    // Packed: hi already normalized, lo 1<<4 then corrected; bit 37 dropped
    apply(3'b001, (75'h1 << 74) | (75'h1 << 37) | 75'h1, {5'd0, 5'd4}, 2'b00, 12'd20,
          12'd7, 2'b00, 14'h0);
    run_beat("pk2");
    chk("pk2_m", m_out, (75'h1 << 74) | (75'h1 << 5));
    chk("pk2_e", 75'(e_out), 75'd15);
    chk("pk2_eh", 75'(eh_out), 75'd7);
    chk("pk2_z", 75'(z_out), 75'(2'b00));

    // Reserved cont 011 treated as wide: sh[6:0] = 96 clamps to 74
    apply(3'b011, 75'h1, {5'd31, 5'd0}, 2'b00, 12'd100, 12'd9, 2'b00, 14'h0);
    run_beat("rsv");
    chk("rsv_m", m_out, 75'h1 << 74);
    chk("rsv_e", 75'(e_out), 75'd26);
    chk("rsv_eh", 75'(eh_out), 75'd0);
    chk("rsv_err", 75'(rsv_err), 75'(1'b1));
    chk("rsv_cont", 75'(cont_out), 75'(3'b011));
    tick();

    // Backpressure: 4 back-to-back beats, out_rdy low for the first 3 cycles
    for (int k = 0; k < 4; k++) bp_exp_e[k] = 12'(10 * k + 1);
    bp_idx = 0;
    bp_got = 0;
    for (int cyc = 0; cyc < 40 && bp_got < 4; cyc++) begin
      if (bp_idx < 4) begin
        apply(3'b000, 75'h1 << 74, 10'd0, 2'b00, bp_exp_e[bp_idx], 12'd0, 2'b00, 14'(bp_idx));
      end else begin
        in_vld = 1'b0;
      end
      out_rdy = (cyc >= 3);
      @(negedge clk);
      bp_fin  = in_vld && in_rdy;
      bp_fout = out_vld && out_rdy;
      if (cyc == 2) begin
        chk("bp_in_rdy_low", 75'(in_rdy), 75'(1'b0));
        chk("bp_hold_vld", 75'(out_vld), 75'(1'b1));
        chk("bp_hold_e", 75'(e_out), 75'(bp_exp_e[0]));
      end
      if (bp_fout) begin
        chk("bp_order_e", 75'(e_out), 75'(bp_exp_e[bp_got]));
        chk("bp_order_trap", 75'(trap_out), 75'(bp_got));
        bp_got = bp_got + 1;
      end
      tick();
      if (bp_fin) bp_idx = bp_idx + 1;
    end
    in_vld = 1'b0;
    chk("bp_all_sent", 75'(bp_idx), 75'd4);
    chk("bp_all_recv", 75'(bp_got), 75'd4);
    tick();
    tick();

    // Flush with both stages full and a beat offered
    out_rdy = 1'b0;
    apply(3'b000, 75'h1 << 74, 10'd0, 2'b00, 12'd1, 12'd0, 2'b00, 14'h0);
    tick();
    apply(3'b000, 75'h1 << 74, 10'd0, 2'b00, 12'd2, 12'd0, 2'b00, 14'h0);
    tick();
    chk("fl_full_vld", 75'(out_vld), 75'(1'b1));
    chk("fl_full_rdy", 75'(in_rdy), 75'(1'b0));
    out_rdy = 1'b1;
    apply(3'b000, 75'h1 << 74, 10'd0, 2'b00, 12'd3, 12'd0, 2'b00, 14'h0);
    flush = 1'b1;
    tick();
    flush  = 1'b0;
    in_vld = 1'b0;
    chk("fl_vld0", 75'(out_vld), 75'(1'b0));
    bp_got = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (out_vld) bp_got = bp_got + 1;
    end
    chk("fl_none", 75'(bp_got), 75'd0);

    // Reserved 111 beat held in a stall, then async reset mid-cycle
    out_rdy = 1'b0;
    apply(3'b111, 75'h1 << 16, 10'd58, 2'b00, 12'd100, 12'd0, 2'b11, 14'h3FFF);
    tick();
    apply(3'b000, 75'h1 << 74, 10'd0, 2'b00, 12'd7, 12'd0, 2'b00, 14'h5);
    tick();
    in_vld = 1'b0;
    chk("r7_vld", 75'(out_vld), 75'(1'b1));
    chk("r7_err", 75'(rsv_err), 75'(1'b1));
    chk("r7_e", 75'(e_out), 75'd42);
    chk("r7_m", m_out, 75'h1 << 74);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_vld", 75'(out_vld), 75'(1'b0));
    chk("ar_m", m_out, 75'h0);
    chk("ar_err", 75'(rsv_err), 75'(1'b0));
    chk("ar_trap", 75'(trap_out), 75'h0);
    chk("ar_cont", 75'(cont_out), 75'h0);
    chk("ar_in_rdy", 75'(in_rdy), 75'(1'b1));
    @(negedge clk);
    rstn    = 1'b1;
    out_rdy = 1'b1;
    bp_got  = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (out_vld) bp_got = bp_got + 1;
    end
    chk("ar_discard", 75'(bp_got), 75'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
